// File: rtl/bsg_print_stat_capture_pkg.sv
// Shared definitions for the print-stat capture block: the capture entry
// layout, the default print-stat EPA and the channel-id width helper.
// Optional build macro: BSG_PRINT_STAT_CAPTURE_DEDUP_EN (per-channel dedup).
`ifndef BSG_PRINT_STAT_CAPTURE_PKG_SV
`define BSG_PRINT_STAT_CAPTURE_PKG_SV

// Capture entry {tag, ch, ts}; widths depend on the instance parameters.
`define BSG_PRINT_STAT_CAPTURE_ENTRY_S(name, tag_w, ch_w, ts_w) \
  typedef struct packed {                                       \
    logic [(tag_w)-1:0] tag;                                    \
    logic [(ch_w)-1:0]  ch;                                     \
    logic [(ts_w)-1:0]  ts;                                     \
  } name

package bsg_print_stat_capture_pkg;

  // EPA that the host code stores to when it wants a stat printed
  localparam logic [27:0] print_stat_epa_gp = 28'h0000_0BFC;

  // Channel-id width: ceil(log2(n)) but never narrower than one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/bsg_print_stat_capture_slot.sv
// One snoop channel: print-stat match compare, pending capture register,
// drop pulse, and (with BSG_PRINT_STAT_CAPTURE_DEDUP_EN) last-accepted-tag
// filtering.
module bsg_print_stat_capture_slot
  import bsg_print_stat_capture_pkg::*;
#(
  parameter int unsigned             addr_width_p      = 28,
  parameter int unsigned             data_width_p      = 32,
  parameter int unsigned             ts_width_p        = 48,
  parameter logic [addr_width_p-1:0] print_stat_addr_p = addr_width_p'(print_stat_epa_gp)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic                    ready_i,
  input  logic                    is_store_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic [ts_width_p-1:0]   ts_i,
  input  logic                    grant_i,
  output logic                    pend_v_o,
  output logic [data_width_p-1:0] pend_tag_o,
  output logic [ts_width_p-1:0]   pend_ts_o,
  output logic                    drop_c
);

  logic                    match_c;
  logic                    accept_c;
  logic                    store_c;
  logic                    pend_v_q,   pend_v_d;
  logic [data_width_p-1:0] pend_tag_q, pend_tag_d;
  logic [ts_width_p-1:0]   pend_ts_q,  pend_ts_d;

  // A completed store transfer to the print-stat EPA
  always_comb begin
    match_c = v_i && ready_i && is_store_i && (addr_i == print_stat_addr_p);
  end

`ifdef BSG_PRINT_STAT_CAPTURE_DEDUP_EN
  logic                    last_v_q,   last_v_d;
  logic [data_width_p-1:0] last_tag_q, last_tag_d;

  // Ignore a repeat of the tag this channel last stored
  always_comb begin
    accept_c = match_c && !(last_v_q && (data_i == last_tag_q));
  end

  // Remember the most recently stored tag
  always_comb begin
    last_v_d   = last_v_q;
    last_tag_d = last_tag_q;
    if (store_c) begin
      last_v_d   = 1'b1;
      last_tag_d = data_i;
    end
  end

  // Dedup history registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_v_q   <= 1'b0;
      last_tag_q <= '0;
    end else begin
      last_v_q   <= last_v_d;
      last_tag_q <= last_tag_d;
    end
  end
`else
  // Every match is a candidate capture
  always_comb begin
    accept_c = match_c;
  end
`endif

  // Pending slot update: a drain frees the slot in time for a same-cycle hit
  always_comb begin
    pend_v_d   = pend_v_q;
    pend_tag_d = pend_tag_q;
    pend_ts_d  = pend_ts_q;
    store_c    = accept_c && (!pend_v_q || grant_i);
    drop_c     = accept_c && pend_v_q && !grant_i;
    if (grant_i) begin
      pend_v_d = 1'b0;
    end
    if (store_c) begin
      pend_v_d   = 1'b1;
      pend_tag_d = data_i;
      pend_ts_d  = ts_i;
    end
  end

  // Pending slot registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_v_q   <= 1'b0;
      pend_tag_q <= '0;
      pend_ts_q  <= '0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_tag_q <= pend_tag_d;
      pend_ts_q  <= pend_ts_d;
    end
  end

  assign pend_v_o   = pend_v_q;
  assign pend_tag_o = pend_tag_q;
  assign pend_ts_o  = pend_ts_q;

endmodule

// File: rtl/bsg_print_stat_capture.sv
// Multi-channel print-stat snoop: per-channel pending slots, a round-robin
// arbiter into a small capture FIFO, a free-running timestamp and a
// saturating drop counter.
// Optional build macro: BSG_PRINT_STAT_CAPTURE_DEDUP_EN (per-channel dedup).
module bsg_print_stat_capture
  import bsg_print_stat_capture_pkg::*;
#(
  parameter int unsigned             num_channels_p    = 2,
  parameter int unsigned             addr_width_p      = 28,
  parameter int unsigned             data_width_p      = 32,
  parameter logic [addr_width_p-1:0] print_stat_addr_p = addr_width_p'(print_stat_epa_gp),
  parameter int unsigned             ts_width_p        = 48,
  parameter int unsigned             fifo_els_p        = 8,
  parameter int unsigned             drop_ctr_width_p  = 16,
  localparam int unsigned            ch_width_lp       = clog2_min1(num_channels_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_channels_p-1:0]              pkt_v_i,
  input  logic [num_channels_p-1:0]              pkt_ready_i,
  input  logic [num_channels_p-1:0]              pkt_is_store_i,
  input  logic [num_channels_p*addr_width_p-1:0] pkt_addr_i,
  input  logic [num_channels_p*data_width_p-1:0] pkt_data_i,
  output logic                                   deq_v_o,
  output logic [data_width_p-1:0]                deq_tag_o,
  output logic [ch_width_lp-1:0]                 deq_ch_o,
  output logic [ts_width_p-1:0]                  deq_ts_o,
  input  logic                                   deq_yumi_i,
  output logic [drop_ctr_width_p-1:0]            drop_count_o
);

  localparam int unsigned fifo_aw_lp        = $clog2(fifo_els_p);
  localparam int unsigned ptr_width_lp      = fifo_aw_lp + 1;
  localparam int unsigned drop_sum_width_lp = drop_ctr_width_p + 5;

  `BSG_PRINT_STAT_CAPTURE_ENTRY_S(entry_s, data_width_p, ch_width_lp, ts_width_p);

  logic [ts_width_p-1:0]        ts_q, ts_d;
  logic [num_channels_p-1:0]    pend_v;
  logic [data_width_p-1:0]      pend_tag [num_channels_p];
  logic [ts_width_p-1:0]        pend_ts  [num_channels_p];
  logic [num_channels_p-1:0]    grant_c;
  logic [num_channels_p-1:0]    drop_c;
  logic [ch_width_lp-1:0]       rr_ptr_q, rr_ptr_d;
  logic                         enq_ready_c;
  logic                         enq_c;
  logic                         deq_c;
  logic                         fifo_full_c;
  logic                         fifo_empty_c;
  entry_s                       enq_entry_c;
  entry_s                       head_c;
  entry_s                       mem_q [fifo_els_p];
  logic [ptr_width_lp-1:0]      wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]      rptr_q, rptr_d;
  logic                         deq_v_q, deq_v_d;
  logic [drop_ctr_width_p-1:0]  drop_count_q, drop_count_d;
  logic [drop_sum_width_lp-1:0] drop_sum_c;

  // One snoop slot per channel
  for (genvar c = 0; c < num_channels_p; c++) begin : g_slot
    bsg_print_stat_capture_slot #(
      .addr_width_p      (addr_width_p),
      .data_width_p      (data_width_p),
      .ts_width_p        (ts_width_p),
      .print_stat_addr_p (print_stat_addr_p)
    ) u_slot (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .v_i        (pkt_v_i[c]),
      .ready_i    (pkt_ready_i[c]),
      .is_store_i (pkt_is_store_i[c]),
      .addr_i     (pkt_addr_i[c*addr_width_p +: addr_width_p]),
      .data_i     (pkt_data_i[c*data_width_p +: data_width_p]),
      .ts_i       (ts_q),
      .grant_i    (grant_c[c]),
      .pend_v_o   (pend_v[c]),
      .pend_tag_o (pend_tag[c]),
      .pend_ts_o  (pend_ts[c]),
      .drop_c     (drop_c[c])
    );
  end

  // Free-running timestamp, wraps silently
  always_comb begin
    ts_d = ts_q + ts_width_p'(1);
  end

  // FIFO status; a full FIFO still accepts when the head leaves this cycle
  always_comb begin
    fifo_empty_c = (wptr_q == rptr_q);
    fifo_full_c  = (wptr_q[fifo_aw_lp] != rptr_q[fifo_aw_lp]) &&
                   (wptr_q[fifo_aw_lp-1:0] == rptr_q[fifo_aw_lp-1:0]);
    deq_c        = deq_yumi_i && !fifo_empty_c;
    enq_ready_c  = !fifo_full_c || deq_c;
  end

  // Round-robin arbiter: search from rr_ptr_q, next search starts after the winner
  always_comb begin
    grant_c     = '0;
    enq_c       = 1'b0;
    enq_entry_c = '0;
    rr_ptr_d    = rr_ptr_q;
    for (int unsigned i = 0; i < num_channels_p; i++) begin
      for (int unsigned j = 0; j < num_channels_p; j++) begin
        if (enq_ready_c && !enq_c && pend_v[j] &&
            (j == ((32'(rr_ptr_q) + i) % num_channels_p))) begin
          enq_c           = 1'b1;
          grant_c[j]      = 1'b1;
          enq_entry_c.tag = pend_tag[j];
          enq_entry_c.ch  = ch_width_lp'(j);
          enq_entry_c.ts  = pend_ts[j];
          rr_ptr_d        = (j == num_channels_p - 1) ? '0 : ch_width_lp'(j + 1);
        end
      end
    end
  end

  // FIFO pointer advance and registered non-empty flag
  always_comb begin
    wptr_d  = wptr_q + ptr_width_lp'(enq_c);
    rptr_d  = rptr_q + ptr_width_lp'(deq_c);
    deq_v_d = (wptr_d != rptr_d);
  end

  // FIFO storage; contents are meaningless until the pointers say otherwise
  always_ff @(posedge clk_i) begin
    if (enq_c) begin
      mem_q[wptr_q[fifo_aw_lp-1:0]] <= enq_entry_c;
    end
  end

  // Saturating accumulation of this cycle's drops
  always_comb begin
    drop_sum_c = drop_sum_width_lp'(drop_count_q);
    for (int unsigned j = 0; j < num_channels_p; j++) begin
      drop_sum_c = drop_sum_c + drop_sum_width_lp'(drop_c[j]);
    end
    if (drop_sum_c > drop_sum_width_lp'({drop_ctr_width_p{1'b1}})) begin
      drop_count_d = '1;
    end else begin
      drop_count_d = drop_ctr_width_p'(drop_sum_c);
    end
  end

  // Control state registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ts_q         <= '0;
      rr_ptr_q     <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      deq_v_q      <= 1'b0;
      drop_count_q <= '0;
    end else begin
      ts_q         <= ts_d;
      rr_ptr_q     <= rr_ptr_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      deq_v_q      <= deq_v_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign head_c       = mem_q[rptr_q[fifo_aw_lp-1:0]];
  assign deq_v_o      = deq_v_q;
  assign deq_tag_o    = head_c.tag;
  assign deq_ch_o     = head_c.ch;
  assign deq_ts_o     = head_c.ts;
  assign drop_count_o = drop_count_q;

  // Consumer may only take an entry that is actually there
  deq_yumi_legal_a : assert property (@(posedge clk_i) disable iff (reset_i)
                                      !(deq_yumi_i && !deq_v_o));

endmodule

// File: tb/tb_bsg_print_stat_capture.sv
// Directed bench for bsg_print_stat_capture: four channels, 8-deep FIFO,
// 2-bit drop counter; a second instance with a 4-bit timestamp shares inputs.
module tb_bsg_print_stat_capture;

  localparam logic [27:0] epa = 28'h0000_0BFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        yumi;
  logic [3:0]  v, rdy, st;
  logic [27:0] addr_arr [4];
  logic [31:0] data_arr [4];
  logic [111:0] addr_pk;
  logic [127:0] data_pk;

  logic        a_deq_v, b_deq_v;
  logic [31:0] a_tag, b_tag;
  logic [1:0]  a_ch, b_ch;
  logic [47:0] a_ts;
  logic [3:0]  b_ts;
  logic [1:0]  a_drop, b_drop;

  int unsigned tb_ts;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    addr_pk = '0;
    data_pk = '0;
    for (int i = 0; i < 4; i++) begin
      addr_pk[i*28 +: 28] = addr_arr[i];
      data_pk[i*32 +: 32] = data_arr[i];
    end
  end

  // Cycle reference matching the timestamp seen during the current cycle
  always @(posedge clk or posedge rst) begin
    if (rst) tb_ts <= 0;
    else     tb_ts <= tb_ts + 1;
  end

  bsg_print_stat_capture #(
    .num_channels_p(4), .addr_width_p(28), .data_width_p(32),
    .ts_width_p(48), .fifo_els_p(8), .drop_ctr_width_p(2)
  ) dut_a (
    .clk_i(clk), .reset_i(rst),
    .pkt_v_i(v), .pkt_ready_i(rdy), .pkt_is_store_i(st),
    .pkt_addr_i(addr_pk), .pkt_data_i(data_pk),
    .deq_v_o(a_deq_v), .deq_tag_o(a_tag), .deq_ch_o(a_ch), .deq_ts_o(a_ts),
    .deq_yumi_i(yumi), .drop_count_o(a_drop)
  );

  bsg_print_stat_capture #(
    .num_channels_p(4), .addr_width_p(28), .data_width_p(32),
    .ts_width_p(4), .fifo_els_p(8), .drop_ctr_width_p(2)
  ) dut_b (
    .clk_i(clk), .reset_i(rst),
    .pkt_v_i(v), .pkt_ready_i(rdy), .pkt_is_store_i(st),
    .pkt_addr_i(addr_pk), .pkt_data_i(data_pk),
    .deq_v_o(b_deq_v), .deq_tag_o(b_tag), .deq_ch_o(b_ch), .deq_ts_o(b_ts),
    .deq_yumi_i(yumi), .drop_count_o(b_drop)
  );

  typedef struct {
    int          ch;
    logic        v;
    logic        rdy;
    logic        st;
    logic [27:0] addr;
    logic [31:0] tag;
    logic        cap;
  } vec_t;

  vec_t vecs [8];

  logic [31:0] exp_tag [11];
  logic [1:0]  exp_ch  [11];
  int unsigned exp_ts  [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v   = '0;
    rdy = '1;
    st  = '1;
    for (int i = 0; i < 4; i++) addr_arr[i] = epa;
  endtask

  task automatic hit(input int ch, input logic [31:0] tag);
    v[ch]        = 1'b1;
    rdy[ch]      = 1'b1;
    st[ch]       = 1'b1;
    addr_arr[ch] = epa;
    data_arr[ch] = tag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int unsigned t0, ta;
  int          cnt;

  initial begin
    vecs[0] = '{0, 1'b1, 1'b1, 1'b1, 28'h0000BFC, 32'h1234, 1'b1};
    vecs[1] = '{0, 1'b1, 1'b1, 1'b0, 28'h0000BFC, 32'h1111, 1'b0};
    vecs[2] = '{0, 1'b1, 1'b0, 1'b1, 28'h0000BFC, 32'h2222, 1'b0};
    vecs[3] = '{1, 1'b0, 1'b1, 1'b1, 28'h0000BFC, 32'h3333, 1'b0};
    vecs[4] = '{2, 1'b1, 1'b1, 1'b1, 28'h0000BF8, 32'h4444, 1'b0};
    vecs[5] = '{3, 1'b1, 1'b1, 1'b1, 28'h0000BFC, 32'hBEEF, 1'b1};
    vecs[6] = '{2, 1'b1, 1'b1, 1'b1, 28'hFFFFBFC, 32'h5555, 1'b0};
    vecs[7] = '{1, 1'b1, 1'b1, 1'b1, 28'h0000BFC, 32'hCAFE, 1'b1};

    rst  = 1'b1;
    yumi = 1'b0;
    for (int i = 0; i < 4; i++) data_arr[i] = '0;
    idle();
    #1;
    check("reset_deq_v", 64'(a_deq_v), 64'd0);
    check("reset_drop", 64'(a_drop), 64'd0);
    check("reset_drop_b", 64'(b_drop), 64'd0);
    step();
    step();
    rst = 1'b0;
    check("release_deq_v", 64'(a_deq_v), 64'd0);

    // Hit at cycle 17 after reset: the 4-bit timestamp has wrapped to 1
    for (int i = 0; i < 40 && tb_ts != 17; i++) step();
    hit(0, 32'h77);
    step();
    idle();
    step();
    check("wrap_deq_v_a", 64'(a_deq_v), 64'd1);
    check("wrap_deq_v_b", 64'(b_deq_v), 64'd1);
    check("wrap_ts_a", 64'(a_ts), 64'd17);
    check("wrap_ts_b", 64'(b_ts), 64'd1);
    check("wrap_tag_b", 64'(b_tag), 64'h77);
    check("wrap_ch_b", 64'(b_ch), 64'd0);
    yumi = a_deq_v;
    step();
    yumi = 1'b0;
    check("wrap_empty", 64'(a_deq_v), 64'd0);

    // Single-cycle match qualification and two-cycle latency
    for (int k = 0; k < 8; k++) begin
      v[vecs[k].ch]        = vecs[k].v;
      rdy[vecs[k].ch]      = vecs[k].rdy;
      st[vecs[k].ch]       = vecs[k].st;
      addr_arr[vecs[k].ch] = vecs[k].addr;
      data_arr[vecs[k].ch] = vecs[k].tag;
      t0 = tb_ts;
      step();
      idle();
      check($sformatf("vec%0d_lat1", k), 64'(a_deq_v), 64'd0);
      step();
      check($sformatf("vec%0d_deq_v", k), 64'(a_deq_v), 64'(vecs[k].cap));
      if (vecs[k].cap) begin
        check($sformatf("vec%0d_tag", k), 64'(a_tag), 64'(vecs[k].tag));
        check($sformatf("vec%0d_ch", k), 64'(a_ch), 64'(vecs[k].ch));
        check($sformatf("vec%0d_ts", k), 64'(a_ts), 64'(t0));
      end
      yumi = a_deq_v;
      step();
      yumi = 1'b0;
      check($sformatf("vec%0d_empty", k), 64'(a_deq_v), 64'd0);
    end

    // Simultaneous bursts on all four channels, consumer always ready
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) hit(c, 32'(b*16 + 10 + c));
      t0 = tb_ts;
      step();
      idle();
      step();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("burst%0d_v%0d", b, k), 64'(a_deq_v), 64'd1);
        check($sformatf("burst%0d_ch%0d", b, k), 64'(a_ch), 64'(k));
        check($sformatf("burst%0d_tag%0d", b, k), 64'(a_tag), 64'(b*16 + 10 + k));
        check($sformatf("burst%0d_ts%0d", b, k), 64'(a_ts), 64'(t0));
        yumi = a_deq_v;
        step();
      end
      yumi = 1'b0;
      check($sformatf("burst%0d_empty", b), 64'(a_deq_v), 64'd0);
      check($sformatf("burst%0d_drop", b), 64'(a_drop), 64'd0);
    end

    // Fill the FIFO from channel 0 with one hit per cycle; the tenth drops
    do_reset();
    t0 = tb_ts;
    for (int i = 0; i < 10; i++) begin
      hit(0, 32'h100 + 32'(i));
      step();
    end
    idle();
    check("fill_drop", 64'(a_drop), 64'd1);
    check("fill_head", 64'(a_tag), 64'h100);
    // Ch1/ch2 slots are empty and take their first hit
    hit(1, 32'h201);
    hit(2, 32'h202);
    ta = tb_ts;
    step();
    idle();
    check("pop_store_drop", 64'(a_drop), 64'd1);
    // Two drops in one cycle
    hit(1, 32'h211);
    hit(2, 32'h212);
    step();
    idle();
    check("pop_two_drop", 64'(a_drop), 64'd3);
    // Three more drops saturate the 2-bit counter
    hit(0, 32'h120);
    hit(1, 32'h221);
    hit(2, 32'h222);
    step();
    idle();
    check("sat_drop", 64'(a_drop), 64'd3);

    for (int i = 0; i < 8; i++) begin
      exp_tag[i] = 32'h100 + 32'(i);
      exp_ch[i]  = 2'd0;
      exp_ts[i]  = t0 + i;
    end
    exp_tag[8]  = 32'h201; exp_ch[8]  = 2'd1; exp_ts[8]  = ta;
    exp_tag[9]  = 32'h202; exp_ch[9]  = 2'd2; exp_ts[9]  = ta;
    exp_tag[10] = 32'h108; exp_ch[10] = 2'd0; exp_ts[10] = t0 + 8;
    for (int k = 0; k < 11; k++) begin
      check($sformatf("drain_v%0d", k), 64'(a_deq_v), 64'd1);
      check($sformatf("drain_tag%0d", k), 64'(a_tag), 64'(exp_tag[k]));
      check($sformatf("drain_ch%0d", k), 64'(a_ch), 64'(exp_ch[k]));
      check($sformatf("drain_ts%0d", k), 64'(a_ts), 64'(exp_ts[k]));
      yumi = a_deq_v;
      step();
    end
    yumi = 1'b0;
    check("drain_empty", 64'(a_deq_v), 64'd0);
    check("drain_drop_hold", 64'(a_drop), 64'd3);

    // Reset in the middle of a cycle with three entries queued
    for (int i = 0; i < 3; i++) begin
      hit(0, 32'h300 + 32'(i));
      step();
    end
    idle();
    step();
    step();
    check("queued_v", 64'(a_deq_v), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_deq_v", 64'(a_deq_v), 64'd0);
    check("async_rst_drop", 64'(a_drop), 64'd0);
    step();
    rst = 1'b0;
    step();
    step();
    check("post_rst_empty", 64'(a_deq_v), 64'd0);

    // Back-to-back repeat of one tag on channel 1
    hit(1, 32'h5);
    step();
    hit(1, 32'h5);
    step();
    idle();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_deq_v) cnt++;
      yumi = a_deq_v;
      step();
    end
    yumi = 1'b0;
`ifdef BSG_PRINT_STAT_CAPTURE_DEDUP_EN
    check("repeat_entries", 64'(cnt), 64'd1);
`else
    check("repeat_entries", 64'(cnt), 64'd2);
`endif
    check("repeat_drop", 64'(a_drop), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
